// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle ALU plus iterative radix-2 mul/div, EX pipeline register.
// Ports: clk/reset/stall/flush control, id_* inputs, ex_* registered outputs, fwd_* forwarding, ex_busy.
module ex_stage_mc #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 30,
  parameter int REG_AW  = 5,
  parameter int MEMOP_W = 2,
  parameter int EXP_W   = 3,
  parameter int EXP_OVF = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  output logic               ex_busy,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               fwd_valid,
  input  logic [ADDR_W-1:0]  id_pc,
  input  logic               id_en,
  input  logic [3:0]         id_alu_op,
  input  logic [DATA_W-1:0]  id_alu_in_0,
  input  logic [DATA_W-1:0]  id_alu_in_1,
  input  logic [MEMOP_W-1:0] id_mem_op,
  input  logic [DATA_W-1:0]  id_mem_wr_data,
  input  logic [REG_AW-1:0]  id_dst_addr,
  input  logic               id_gpr_we_,
  input  logic [EXP_W-1:0]   id_exp_code,
  output logic [ADDR_W-1:0]  ex_pc,
  output logic               ex_en,
  output logic [MEMOP_W-1:0] ex_mem_op,
  output logic [DATA_W-1:0]  ex_mem_wr_data,
  output logic [REG_AW-1:0]  ex_dst_addr,
  output logic               ex_gpr_we_,
  output logic [EXP_W-1:0]   ex_exp_code,
  output logic [DATA_W-1:0]  ex_out
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_MULHU = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_REMU  = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [DATA_W-1:0] a, b;
  assign a = id_alu_in_0;
  assign b = id_alu_in_1;

  // ---------------- single-cycle ALU ----------------
  logic [DATA_W-1:0] alu_res, sum, diff;
  logic [SH_W-1:0]   shamt;
  logic              ovf, single_op, mdu_op;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SH_W-1:0];

  assign single_op = (id_alu_op >= OP_ADD) && (id_alu_op <= OP_SRA);
  assign mdu_op    = (id_alu_op >= OP_MUL) && (id_alu_op <= OP_REMU);

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (id_alu_op)
      OP_ADD: begin
        alu_res = sum;
        ovf = (a[DATA_W-1] == b[DATA_W-1]) &&
              (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        ovf = (a[DATA_W-1] != b[DATA_W-1]) &&
              (diff[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      OP_SRA: alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // ---------------- iterative mul/div ----------------
  // acc_q holds the high product / partial remainder,
  // lo_q the multiplier -> low product, or dividend -> quotient.
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [3:0]        op_q, op_d;

  logic              start, id_div, run_div;
  logic [DATA_W:0]   msum;
  logic [DATA_W:0]   rs;
  logic              rs_lt_b;
  logic [DATA_W-1:0] mdu_res;

  assign start   = (state_q == S_IDLE) && id_en && mdu_op && !flush;
  assign id_div  = (id_alu_op == OP_DIVU) || (id_alu_op == OP_REMU);
  assign run_div = (op_q == OP_DIVU) || (op_q == OP_REMU);

  assign msum    = {1'b0, acc_q} +
                   (lo_q[0] ? {1'b0, b_q} : '0);
  assign rs      = {acc_q, lo_q[DATA_W-1]};
  assign rs_lt_b = rs < {1'b0, b_q};

  assign mdu_res = ((op_q == OP_MULHU) || (op_q == OP_REMU))
                   ? acc_q : lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = id_alu_op;
          b_d   = b;
          lo_d  = a;
          acc_d = '0;
          cnt_d = CNT_W'(DATA_W);
          // x/0: quotient all ones, remainder = dividend
          if (id_div && (b == '0)) begin
            acc_d   = a;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (run_div) begin
          if (rs_lt_b) begin
            acc_d = rs[DATA_W-1:0];
            lo_d  = {lo_q[DATA_W-2:0], 1'b0};
          end else begin
            // difference < b, so the low DATA_W bits are exact
            acc_d = rs[DATA_W-1:0] - b_q;
            lo_d  = {lo_q[DATA_W-2:0], 1'b1};
          end
        end else begin
          acc_d = msum[DATA_W:1];
          lo_d  = {msum[0], lo_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  assign ex_busy   = start || (state_q == S_RUN);
  assign fwd_valid = id_en && (single_op || (state_q == S_DONE));
  assign fwd_data  = (state_q == S_DONE) ? mdu_res : alu_res;

  // ---------------- EX pipeline register ----------------
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               en_q, en_d;
  logic [MEMOP_W-1:0] mop_q, mop_d;
  logic [DATA_W-1:0]  wdat_q, wdat_d;
  logic [REG_AW-1:0]  dst_q, dst_d;
  logic               we_q, we_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [DATA_W-1:0]  out_q, out_d;

  always_comb begin
    pc_d   = pc_q;
    en_d   = en_q;
    mop_d  = mop_q;
    wdat_d = wdat_q;
    dst_d  = dst_q;
    we_d   = we_q;
    exp_d  = exp_q;
    out_d  = out_q;
    if (flush || (!stall && (ex_busy || !id_en))) begin
      pc_d   = '0;
      en_d   = 1'b0;
      mop_d  = '0;
      wdat_d = '0;
      dst_d  = '0;
      we_d   = 1'b1;
      exp_d  = '0;
      out_d  = '0;
    end else if (!stall) begin
      pc_d   = id_pc;
      en_d   = 1'b1;
      mop_d  = id_mem_op;
      wdat_d = id_mem_wr_data;
      dst_d  = id_dst_addr;
      we_d   = id_gpr_we_;
      exp_d  = id_exp_code;
      out_d  = fwd_data;
      // an upstream exception takes precedence over overflow
      if ((id_exp_code == '0) && ovf) begin
        exp_d = EXP_W'(EXP_OVF);
        we_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      op_q    <= '0;
      pc_q    <= '0;
      en_q    <= 1'b0;
      mop_q   <= '0;
      wdat_q  <= '0;
      dst_q   <= '0;
      we_q    <= 1'b1;
      exp_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      op_q    <= op_d;
      pc_q    <= pc_d;
      en_q    <= en_d;
      mop_q   <= mop_d;
      wdat_q  <= wdat_d;
      dst_q   <= dst_d;
      we_q    <= we_d;
      exp_q   <= exp_d;
      out_q   <= out_d;
    end
  end

  assign ex_pc          = pc_q;
  assign ex_en          = en_q;
  assign ex_mem_op      = mop_q;
  assign ex_mem_wr_data = wdat_q;
  assign ex_dst_addr    = dst_q;
  assign ex_gpr_we_     = we_q;
  assign ex_exp_code    = exp_q;
  assign ex_out         = out_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: ALU, overflow, mul/div timing, flush, stall, reset.
// Ports: none (top-level bench).
module tb_ex_stage_mc;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        ex_busy, fwd_valid;
  logic [31:0] fwd_data;
  logic [29:0] id_pc;
  logic        id_en;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0, id_alu_in_1;
  logic [1:0]  id_mem_op;
  logic [31:0] id_mem_wr_data;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic [2:0]  id_exp_code;
  logic [29:0] ex_pc;
  logic        ex_en;
  logic [1:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data;
  logic [4:0]  ex_dst_addr;
  logic        ex_gpr_we_;
  logic [2:0]  ex_exp_code;
  logic [31:0] ex_out;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  ex_stage_mc dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_busy(ex_busy), .fwd_data(fwd_data), .fwd_valid(fwd_valid),
    .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
    .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
    .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
    .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
    .id_exp_code(id_exp_code),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
    .ex_out(ex_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    id_en       = 1'b1;
    id_alu_op   = op;
    id_alu_in_0 = a;
    id_alu_in_1 = b;
    id_gpr_we_  = 1'b0;
    id_exp_code = 3'd0;
    id_pc       = 30'h155;
    id_dst_addr = 5'd7;
    id_mem_op   = 2'd0;
  endtask

  task automatic nop();
    id_en     = 1'b0;
    id_alu_op = 4'd0;
  endtask

  // counts busy cycles starting from the current (already settled) cycle
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int g = 0; g < 100 && ex_busy; g++) begin
      cnt++;
      step();
    end
  endtask

  task automatic run_mdu(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_n, input logic [31:0] exp_r);
    int c;
    drive(op, a, b);
    #1;
    count_busy(c);
    chk({tag, "_busy_len"}, c, exp_n);
    chk({tag, "_done_fv"}, fwd_valid, 1);
    chk({tag, "_done_fd"}, fwd_data, exp_r);
    step();
    chk({tag, "_ex_out"}, ex_out, exp_r);
    chk({tag, "_ex_en"}, ex_en, 1);
    nop();
    step();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_mem_wr_data = 32'h0;
    drive(4'd0, 32'h0, 32'h0);
    nop();
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_en", ex_en, 0);
    chk("rst_we", ex_gpr_we_, 1);
    chk("rst_out", ex_out, 0);
    chk("rst_exp", ex_exp_code, 0);
    chk("rst_busy", ex_busy, 0);

    // ADD overflow
    drive(4'd1, 32'h7FFF_FFFF, 32'h1);
    #1;
    chk("add_fv", fwd_valid, 1);
    step();
    chk("add_out", ex_out, 32'h8000_0000);
    chk("add_exp", ex_exp_code, 3);
    chk("add_we", ex_gpr_we_, 1);
    chk("add_en", ex_en, 1);
    chk("add_pc", ex_pc, 30'h155);

    // SUB, no overflow
    drive(4'd2, 32'd10, 32'd3);
    step();
    chk("sub_out", ex_out, 7);
    chk("sub_exp", ex_exp_code, 0);
    chk("sub_we", ex_gpr_we_, 0);

    // XOR
    drive(4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF);
    step();
    chk("xor_out", ex_out, 32'hFF00_EDCB);
    nop();
    step();

    run_mdu("mul",   4'd9,  32'h0001_0000, 32'h0003_0000, 33, 32'h0);
    run_mdu("mulhu", 4'd10, 32'h0001_0000, 32'h0003_0000, 33, 32'h3);
    run_mdu("mul2",  4'd9,  32'h0001_2345, 32'h0000_0100, 33, 32'h0123_4500);
    run_mdu("divu",  4'd11, 32'd100, 32'd7, 33, 32'd14);
    run_mdu("remu",  4'd12, 32'd100, 32'd7, 33, 32'd2);
    run_mdu("divz",  4'd11, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_mdu("remz",  4'd12, 32'd5, 32'd0, 1, 32'd5);

    // flush in the 10th busy cycle of DIVU
    drive(4'd11, 32'd100, 32'd7);
    #1;
    repeat (9) step();
    chk("fl_busy_pre", ex_busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(4'd1, 32'd2, 32'd3);
    #1;
    chk("fl_busy", ex_busy, 0);
    chk("fl_en", ex_en, 0);
    step();
    chk("fl_add_out", ex_out, 5);
    chk("fl_add_en", ex_en, 1);
    nop();
    step();

    // stall from the 20th busy cycle to 5 cycles past DONE
    drive(4'd9, 32'h0001_2345, 32'h0000_0100);
    #1;
    repeat (19) step();
    chk("st_busy20", ex_busy, 1);
    stall = 1'b1;
    for (int g = 0; g < 50 && !fwd_valid; g++) step();
    chk("st_done_fv", fwd_valid, 1);
    chk("st_done_busy", ex_busy, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_hold_fv", fwd_valid, 1);
      chk("st_hold_fd", fwd_data, 32'h0123_4500);
      chk("st_hold_en", ex_en, 0);
    end
    stall = 1'b0;
    step();
    chk("st_out", ex_out, 32'h0123_4500);
    chk("st_en", ex_en, 1);
    nop();
    #1;
    chk("st_busy", ex_busy, 0);
    step();

    // reset mid-MUL
    drive(4'd9, 32'd3, 32'd5);
    #1;
    repeat (5) step();
    chk("rm_busy_pre", ex_busy, 1);
    reset = 1'b1;
    nop();
    step();
    reset = 1'b0;
    chk("rm_en", ex_en, 0);
    chk("rm_we", ex_gpr_we_, 1);
    chk("rm_out", ex_out, 0);
    chk("rm_busy", ex_busy, 0);
    step();
    chk("rm_idle_fv", fwd_valid, 0);

    // back-to-back shifts
    drive(4'd6, 32'h1, 32'd31);
    step();
    chk("sll_out", ex_out, 32'h8000_0000);
    drive(4'd8, 32'h8000_0000, 32'd4);
    step();
    chk("sra_out", ex_out, 32'hF800_0000);
    drive(4'd7, 32'h8000_0000, 32'd4);
    step();
    chk("srl_out", ex_out, 32'h0800_0000);
    nop();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
